// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared constants for the snake game blocks: cell-grid
//                limits, master state encodings and the target generator's
//                FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Largest legal cell indices of the 160x120 gameplay grid
    localparam logic [7:0] MAX_X = 8'd159;
    localparam logic [6:0] MAX_Y = 7'd119;

    // Master state machine encodings
    localparam logic [1:0] MSM_IDLE = 2'b00;
    localparam logic [1:0] MSM_PLAY = 2'b01;
    localparam logic [1:0] MSM_WIN  = 2'b10;
    localparam logic [1:0] MSM_LOSE = 2'b11;

    // Target generator FSM
    typedef enum logic [0:0] {
        TG_IDLE   = 1'b0,
        TG_SEARCH = 1'b1
    } tg_state_t;

    // True when a cell coordinate lies inside the gameplay grid
    function automatic logic cell_in_range(input logic [7:0] x, input logic [6:0] y);
        return (x <= MAX_X) && (y <= MAX_Y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Free-running Fibonacci LFSR. Shifts left every cycle with the
//                XOR of the tapped bits fed into bit 0. Reset loads SEED; the
//                register is never gated, so a non-zero SEED keeps it non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    // TAPS is a bit mask: bit (n-1) set means tap n participates in feedback
    assign w_fb = ^(r_q & TAPS);

    // Shift register: seed on reset, advance unconditionally otherwise
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[WIDTH-2:0], w_fb};
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/target_generator.sv
`default_nettype none
// ============================================================================
//  Module      : target_generator
//  Description : Holds the red target cell position. On a rising edge of
//                TARGET_REACHED during play it searches the two LFSR streams
//                for an in-range cell different from the current target,
//                commits it and pulses NEW_TARGET. A 00->01 master state
//                transition reloads the initial target position.
//  Options     : AVOID_HEAD_EN - when defined, candidates equal to the snake
//                head position (HEAD_X, HEAD_Y) are also rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module target_generator
    import snake_pkg::*;
#(
    parameter logic [7:0] INIT_X = 8'd40,
    parameter logic [6:0] INIT_Y = 7'd30,
    parameter logic [7:0] SEED_X = 8'hA5,
    parameter logic [6:0] SEED_Y = 7'h2B
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic       TARGET_REACHED,
    input  logic [7:0] HEAD_X,
    input  logic [6:0] HEAD_Y,
    output logic [7:0] TARGET_ADDR_H,
    output logic [6:0] TARGET_ADDR_V,
    output logic       NEW_TARGET,
    output logic       BUSY
);

    // Tap masks: X uses taps 8,6,5,4; Y uses taps 7,6 (both maximal length)
    localparam logic [7:0] c_taps_x = 8'hB8;
    localparam logic [6:0] c_taps_y = 7'h60;

    tg_state_t  r_state;
    tg_state_t  w_state_next;

    logic       r_reached;
    logic [1:0] r_msm_prev;
    logic [7:0] r_tgt_h;
    logic [6:0] r_tgt_v;
    logic       r_new_target;

    logic [7:0] w_cand_x;
    logic [6:0] w_cand_y;
    logic       w_rise;
    logic       w_playing;
    logic       w_new_game;
    logic       w_cand_valid;
    logic       w_commit;

    lfsr_gen #(
        .WIDTH (8),
        .TAPS  (c_taps_x),
        .SEED  (SEED_X)
    ) u_lfsr_x (
        .CLK   (CLK),
        .RESET (RESET),
        .Q     (w_cand_x)
    );

    lfsr_gen #(
        .WIDTH (7),
        .TAPS  (c_taps_y),
        .SEED  (SEED_Y)
    ) u_lfsr_y (
        .CLK   (CLK),
        .RESET (RESET),
        .Q     (w_cand_y)
    );

    assign w_rise     = TARGET_REACHED & ~r_reached;
    assign w_playing  = (MSM_STATE == MSM_PLAY);
    assign w_new_game = (r_msm_prev == MSM_IDLE) && w_playing;

`ifdef AVOID_HEAD_EN
    // Also refuse to spawn the target underneath the snake head
    assign w_cand_valid = cell_in_range(w_cand_x, w_cand_y)
                       && !((w_cand_x == r_tgt_h) && (w_cand_y == r_tgt_v))
                       && !((w_cand_x == HEAD_X) && (w_cand_y == HEAD_Y));
`else
    logic w_head_unused;
    assign w_head_unused = ^{HEAD_X, HEAD_Y};

    assign w_cand_valid = cell_in_range(w_cand_x, w_cand_y)
                       && !((w_cand_x == r_tgt_h) && (w_cand_y == r_tgt_v));
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= TG_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start on a qualified rise, abort when play ends,
    // otherwise keep retrying until the LFSRs present a valid cell
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            TG_IDLE: begin
                if (w_rise && w_playing) begin
                    w_state_next = TG_SEARCH;
                end
            end
            TG_SEARCH: begin
                if (!w_playing) begin
                    w_state_next = TG_IDLE;
                end else if (w_cand_valid) begin
                    w_commit     = 1'b1;
                    w_state_next = TG_IDLE;
                end
            end
            default: begin
                w_state_next = TG_IDLE;
            end
        endcase
    end

    // Edge detector, master-state history, target registers and pulse.
    // A new game cannot coincide with a commit (SEARCH implies the previous
    // master state was already PLAY), so the reload simply takes priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_reached    <= 1'b0;
            r_msm_prev   <= MSM_IDLE;
            r_tgt_h      <= INIT_X;
            r_tgt_v      <= INIT_Y;
            r_new_target <= 1'b0;
        end else begin
            r_reached    <= TARGET_REACHED;
            r_msm_prev   <= MSM_STATE;
            r_new_target <= w_commit;
            if (w_new_game) begin
                r_tgt_h <= INIT_X;
                r_tgt_v <= INIT_Y;
            end else if (w_commit) begin
                r_tgt_h <= w_cand_x;
                r_tgt_v <= w_cand_y;
            end
        end
    end

    assign TARGET_ADDR_H = r_tgt_h;
    assign TARGET_ADDR_V = r_tgt_v;
    assign NEW_TARGET    = r_new_target;
    assign BUSY          = (r_state == TG_SEARCH);

endmodule
`default_nettype wire

// File: tb/tb_target_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_target_generator
//  Description : Self-checking bench for target_generator. A cycle-level
//                reference model built from the LFSR bit-stream recurrences
//                predicts the outputs every cycle; directed phases check the
//                reset state, single and repeated requests, abort, new game
//                and head avoidance, then a randomized phase runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_target_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] msm = 2'b00;
    logic       tr  = 1'b0;
    logic [7:0] hx  = 8'd0;
    logic [6:0] hy  = 7'd0;
    logic [7:0] th;
    logic [6:0] tv;
    logic       nt;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    target_generator dut (
        .CLK            (clk),
        .RESET          (rst),
        .MSM_STATE      (msm),
        .TARGET_REACHED (tr),
        .HEAD_X         (hx),
        .HEAD_Y         (hy),
        .TARGET_ADDR_H  (th),
        .TARGET_ADDR_V  (tv),
        .NEW_TARGET     (nt),
        .BUSY           (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // LFSR value tables, generated from the bit-stream recurrences:
    //   X: s[n] = s[n-8]^s[n-6]^s[n-5]^s[n-4], register bit i = s[k+7-i]
    //   Y: s[n] = s[n-7]^s[n-6],               register bit i = s[k+6-i]
    // ------------------------------------------------------------------
    logic [7:0] seqx [0:254];
    logic [6:0] seqy [0:126];
    logic [7:0] wrapx;
    logic [6:0] wrapy;

    task automatic build_tables();
        bit         sx [0:262];
        bit         sy [0:133];
        logic [7:0] seed_x;
        logic [6:0] seed_y;
        logic [7:0] st8;
        logic [6:0] st7;
        seed_x = 8'hA5;
        seed_y = 7'h2B;
        for (int k = 0; k < 8; k++) sx[k] = seed_x[7-k];
        for (int n = 8; n < 263; n++) sx[n] = sx[n-8] ^ sx[n-6] ^ sx[n-5] ^ sx[n-4];
        for (int k = 0; k < 7; k++) sy[k] = seed_y[6-k];
        for (int n = 7; n < 134; n++) sy[n] = sy[n-7] ^ sy[n-6];
        for (int k = 0; k <= 255; k++) begin
            for (int i = 0; i < 8; i++) st8[i] = sx[k+7-i];
            if (k < 255) seqx[k] = st8; else wrapx = st8;
        end
        for (int k = 0; k <= 127; k++) begin
            for (int i = 0; i < 7; i++) st7[i] = sy[k+6-i];
            if (k < 127) seqy[k] = st7; else wrapy = st7;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: target position, pending-search flag and pulse,
    // with the candidate at each clock given by the number of clocks
    // since reset indexed into the LFSR tables.
    // ------------------------------------------------------------------
    logic [7:0] m_h;
    logic [6:0] m_v;
    logic       m_nt;
    logic       m_search;
    logic       m_reached;
    logic [1:0] m_prev;
    int         m_idx = 0;
    int         m_ix;
    int         m_iy;
    logic [7:0] m_cx;
    logic [6:0] m_cy;
    logic       m_valid;
    logic       m_rise;

    assign m_ix   = m_idx % 255;
    assign m_iy   = m_idx % 127;
    assign m_cx   = seqx[m_ix];
    assign m_cy   = seqy[m_iy];
    assign m_rise = tr && !m_reached;
`ifdef AVOID_HEAD_EN
    assign m_valid = (m_cx <= 8'd159) && (m_cy <= 7'd119) && !(m_cx == m_h && m_cy == m_v)
                  && !(m_cx == hx && m_cy == hy);
`else
    assign m_valid = (m_cx <= 8'd159) && (m_cy <= 7'd119) && !(m_cx == m_h && m_cy == m_v);
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_h       <= 8'd40;
            m_v       <= 7'd30;
            m_nt      <= 1'b0;
            m_search  <= 1'b0;
            m_reached <= 1'b0;
            m_prev    <= 2'b00;
            m_idx     <= 0;
        end else begin
            m_reached <= tr;
            m_prev    <= msm;
            m_idx     <= m_idx + 1;
            m_nt      <= 1'b0;
            if (!m_search) begin
                if (m_rise && msm == 2'b01) m_search <= 1'b1;
            end else if (msm != 2'b01) begin
                m_search <= 1'b0;
            end else if (m_valid) begin
                m_h      <= m_cx;
                m_v      <= m_cy;
                m_nt     <= 1'b1;
                m_search <= 1'b0;
            end
            if (m_prev == 2'b00 && msm == 2'b01) begin
                m_h <= 8'd40;
                m_v <= 7'd30;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input logic [31:0] a, input logic [31:0] b);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s: values %0d / %0d violate the rule at time %0t", name, a, b, $time);
        end
    endtask

    // Per-cycle compare against the model, plus the search-length bound
    bit chk_en   = 1'b0;
    int busy_run = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("target_h", {24'd0, th}, {24'd0, m_h});
            check("target_v", {25'd0, tv}, {25'd0, m_v});
            check("new_target", {31'd0, nt}, {31'd0, m_nt});
            check("busy", {31'd0, busy}, {31'd0, m_search});
            busy_run = busy ? busy_run + 1 : 0;
            check_true("busy_length", busy_run <= 32385, busy_run, 32385);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_nt(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 32400; i++) begin
            @(negedge clk);
            if (nt) begin
                ok = 1'b1;
                break;
            end
        end
        check_true(name, ok, 0, 32400);
    endtask

    initial begin
        logic [7:0] ph;
        logic [6:0] pv;
        int         pulses;
        int         first_at;
        int         j;
        bit         found;

        build_tables();

        // Hand-computed pins of the model tables
        check("seqx_1", {24'd0, seqx[1]}, 32'h4A);
        check("seqy_1", {25'd0, seqy[1]}, 32'h57);
        check("wrapx_255", {24'd0, wrapx}, 32'hA5);
        check("wrapy_127", {25'd0, wrapy}, 32'h2B);

        // Reset state
        rst = 1'b1;
        tick(3);
        check("reset_h", {24'd0, th}, 40);
        check("reset_v", {25'd0, tv}, 30);
        check("reset_nt", {31'd0, nt}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        chk_en = 1'b1;
        rst    = 1'b0;
        msm    = 2'b01;
        tick(2);

        // Basic request: a long level yields exactly one pulse
        tr       = 1'b1;
        pulses   = 0;
        first_at = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (nt) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i + 1;
                    check_true("basic_range", th <= 8'd159 && tv <= 7'd119, th, tv);
                    check_true("basic_moved", !(th == 8'd40 && tv == 7'd30), th, tv);
                end
            end
        end
        check("basic_pulses", pulses, 1);
        check_true("basic_latency", first_at >= 2, first_at, 2);

        // Repeated requests with low gaps
        for (int r = 0; r < 500; r++) begin
            tr = 1'b0;
            tick(10 + int'($urandom_range(0, 3)));
            ph = th;
            pv = tv;
            tr = 1'b1;
            wait_nt("repeat_timeout");
            check_true("repeat_range", th <= 8'd159 && tv <= 7'd119, th, tv);
            check_true("repeat_differs", !(th == ph && tv == pv), th, tv);
            tick(int'($urandom_range(0, 4)));
        end

        // Abort: play ends while searching
        tr = 1'b0;
        tick(3);
        ph = th;
        pv = tv;
        tr = 1'b1;
        tick(1);
        check("abort_busy_before", {31'd0, busy}, 1);
        msm = 2'b11;
        tick(1);
        check("abort_busy_after", {31'd0, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_nt", {31'd0, nt}, 0);
            tick(1);
        end
        check("abort_h", {24'd0, th}, {24'd0, ph});
        check("abort_v", {25'd0, tv}, {25'd0, pv});

        // New game: 10 -> 00 -> 01; a rise while idle does not search
        msm = 2'b10;
        tr  = 1'b0;
        tick(3);
        msm = 2'b00;
        tick(2);
        tr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("idle_rise_busy", {31'd0, busy}, 0);
        end
        msm = 2'b01;
        tick(1);
        check("newgame_h", {24'd0, th}, 40);
        check("newgame_v", {25'd0, tv}, 30);
        check("newgame_nt", {31'd0, nt}, 0);
        check("newgame_busy", {31'd0, busy}, 0);

        // Head placed on the first candidate that range/inequality would accept
        for (int r = 0; r < 20; r++) begin
            tr = 1'b0;
            tick(5);
            found = 1'b0;
            j     = m_idx + 1;
            for (int k = 0; k < 32385 && !found; k++) begin
                if (seqx[(j + k) % 255] <= 8'd159 && seqy[(j + k) % 127] <= 7'd119 &&
                    !(seqx[(j + k) % 255] == th && seqy[(j + k) % 127] == tv)) begin
                    found = 1'b1;
                    j     = j + k;
                end
            end
            hx = seqx[j % 255];
            hy = seqy[j % 127];
            tr = 1'b1;
            wait_nt("head_timeout");
`ifdef AVOID_HEAD_EN
            check_true("head_avoided", !(th == hx && tv == hy), th, hx);
`else
            check_true("head_allowed", th == hx && tv == hy, th, hx);
`endif
        end

        // Randomized traffic, including resets and master-state changes
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) msm = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 9) == 0) msm = 2'b01;
            if ($urandom_range(0, 7) == 0) tr = ~tr;
            if ($urandom_range(0, 3) == 0) begin
                hx = m_cx;
                hy = m_cy;
            end else begin
                hx = 8'($urandom_range(0, 255));
                hy = 7'($urandom_range(0, 127));
            end
        end
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
